// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared state, parity and error-bit definitions for the UART receiver
package uart_rx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, STOP2} state_e;
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;
  localparam int ERR_PARITY = 0;
  localparam int ERR_STOP   = 1;
  localparam int ERR_BREAK  = 2;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous show-ahead FIFO with full/empty/count
module uart_rx_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic wr, rd;
  always_comb begin
    count = wptr_q - rptr_q;
    full = count == (AW+1)'(DEPTH);
    empty = count == '0;
    wr = push & (~full | pop);
    rd = pop & ~empty;
    wptr_d = wptr_q + {{AW{1'b0}}, wr};
    rptr_d = rptr_q + {{AW{1'b0}}, rd};
    mem_d = mem_q;
    if (wr) mem_d[wptr_q[AW-1:0]] = wdata;
    rdata = empty ? '0 : mem_q[rptr_q[AW-1:0]];
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end
  always_ff @(posedge clock) mem_q <= mem_d;
endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver with runtime framing and a receive FIFO
module uart_rx_core import uart_rx_pkg::*; #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          data_tx,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [1:0]                    parity_type,
  input  logic                          stop_bits,
  input  logic                          rd_en,
  output logic                          valid,
  output logic [DATA_BITS-1:0]          data_out,
  output logic [2:0]                    error_flag,
  output logic                          overrun_flag,
  output logic                          active_flag,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int TW = $clog2(OVERSAMPLE);
  state_e state_q, state_d;
  logic [2:0] sync_q, sync_d;
  logic [DIV_W-1:0] div_q, div_d, cnt_q, cnt_d;
  logic [1:0] par_q, par_d;
  logic stop_q, stop_d, perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic [TW-1:0] tc_q, tc_d;
  logic [3:0] bits_q, bits_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [2:0] err;
  logic [DATA_BITS+2:0] head;
  logic rx, fall, tick, mid, last, push, pop, full, empty;
  assign rx = sync_q[1];
  assign fall = sync_q[2] & ~sync_q[1];
  assign tick = cnt_q == '0;
  assign mid = tick && tc_q == TW'(OVERSAMPLE/2-1);
  assign last = tick && tc_q == TW'(OVERSAMPLE-1);
  assign pop = rd_en & ~empty;
  assign err[ERR_PARITY] = perr_q;
  assign err[ERR_STOP] = ferr_d;
  assign err[ERR_BREAK] = (data_q == '0) & ferr_d;
  always_comb begin
    sync_d = {sync_q[1:0], data_tx};
    state_d = state_q;
    div_d = div_q;
    par_d = par_q;
    stop_d = stop_q;
    tc_d = (tick && state_q != IDLE) ? tc_q + 1'b1 : tc_q;
    bits_d = bits_q;
    data_d = data_q;
    perr_d = perr_q;
    ferr_d = ferr_q;
    push = 1'b0;
    cnt_d = state_q == IDLE ? baud_div : tick ? div_q : cnt_q - 1'b1;
    case (state_q)
      IDLE: if (fall) begin
        state_d = START;
        tc_d = '0;
        bits_d = '0;
        div_d = baud_div;
        par_d = parity_type;
        stop_d = stop_bits;
        perr_d = 1'b0;
        ferr_d = 1'b0;
      end
      START: if (mid) begin
        state_d = rx ? IDLE : DATA;
        tc_d = '0;
      end
      DATA: if (last) begin
        data_d = {rx, data_q[DATA_BITS-1:1]};
        bits_d = bits_q + 1'b1;
        tc_d = '0;
        if (bits_q == 4'(DATA_BITS-1)) state_d = (par_q == PAR_ODD || par_q == PAR_EVEN) ? PARITY : STOP;
      end
      PARITY: if (last) begin
        perr_d = (^data_q ^ rx) != (par_q == PAR_ODD);
        tc_d = '0;
        state_d = STOP;
      end
      STOP: if (last) begin
        ferr_d = ~rx;
        tc_d = '0;
        state_d = stop_q ? STOP2 : IDLE;
        push = ~stop_q;
      end
      STOP2: if (last) begin
        ferr_d = ferr_q | ~rx;
        state_d = IDLE;
        push = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    ovr_d = pop ? 1'b0 : (push & full) | ovr_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '1;
      state_q <= IDLE;
      div_q <= '0;
      cnt_q <= '0;
      par_q <= '0;
      stop_q <= 1'b0;
      tc_q <= '0;
      bits_q <= '0;
      data_q <= '0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      state_q <= state_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
      par_q <= par_d;
      stop_q <= stop_d;
      tc_q <= tc_d;
      bits_q <= bits_d;
      data_q <= data_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
      ovr_q <= ovr_d;
    end
  end
  uart_rx_fifo #(.WIDTH(DATA_BITS+3), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(push),
    .pop(pop),
    .wdata({err, data_q}),
    .rdata(head),
    .full(full),
    .empty(empty),
    .count(fifo_count)
  );
  assign valid = ~empty;
  assign data_out = head[DATA_BITS-1:0];
  assign error_flag = head[DATA_BITS+:3];
  assign overrun_flag = ovr_q;
  assign active_flag = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: random and directed frames checked against a frame-level FIFO model
module tb_uart_rx_core;
  localparam int DB = 8;
  localparam int OS = 16;
  localparam int DW = 16;
  localparam int FD = 4;
  logic clock = 0, reset = 1, data_tx = 1, stop_bits = 0, rd_en = 0;
  logic [DW-1:0] baud_div = 3;
  logic [1:0] parity_type = 0;
  logic valid, overrun_flag, active_flag;
  logic [DB-1:0] data_out;
  logic [2:0] error_flag;
  logic [2:0] fifo_count;
  uart_rx_core #(.DATA_BITS(DB), .OVERSAMPLE(OS), .DIV_W(DW), .FIFO_DEPTH(FD)) dut (
    .clock(clock),
    .reset(reset),
    .data_tx(data_tx),
    .baud_div(baud_div),
    .parity_type(parity_type),
    .stop_bits(stop_bits),
    .rd_en(rd_en),
    .valid(valid),
    .data_out(data_out),
    .error_flag(error_flag),
    .overrun_flag(overrun_flag),
    .active_flag(active_flag),
    .fifo_count(fifo_count)
  );
  always #5 clock = ~clock;
  int ncmp = 0, nfail = 0, cyc = 0, t_start = 0, rise_cyc = 0;
  logic [10:0] exp_q[$];
  logic exp_ovr = 0, chk_en = 0, vprev = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  function automatic logic par_bit(input logic [7:0] d, input logic [1:0] pt, input logic bad);
    return (^d) ^ (pt == 2'b01) ^ bad;
  endfunction
  function automatic logic [10:0] entry(input logic [7:0] d, input logic [1:0] pt, input logic sb,
                                        input logic p, input logic s1, input logic s2);
    logic pe, fe;
    pe = (pt == 2'b01 || pt == 2'b10) && ((^d ^ p) != (pt == 2'b01));
    fe = !s1 || (sb && !s2);
    return {d == 8'h00 && fe, fe, pe, d};
  endfunction
  task automatic model_push(input logic [10:0] e);
    if (exp_q.size() >= FD) exp_ovr = 1;
    else exp_q.push_back(e);
  endtask
  task automatic model_pop();
    if (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      exp_ovr = 0;
    end
  endtask
  always @(posedge clock) cyc++;
  always @(negedge clock) begin
    if (valid && !vprev) rise_cyc = cyc;
    vprev = valid;
  end
  always @(negedge clock) begin
    logic [10:0] h;
    if (chk_en) begin
      h = exp_q.size() > 0 ? exp_q[0] : 11'h0;
      chk("valid", valid, exp_q.size() > 0);
      chk("fifo_count", fifo_count, exp_q.size());
      chk("data_out", data_out, h[7:0]);
      chk("error_flag", error_flag, h[10:8]);
      chk("overrun_flag", overrun_flag, exp_ovr);
      chk("active_flag", active_flag, 0);
    end
  end
  task automatic wait_n(input int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic pop1();
    rd_en = 1;
    @(posedge clock);
    model_pop();
    @(negedge clock);
    rd_en = 0;
  endtask
  task automatic drain();
    while (exp_q.size() > 0) pop1();
  endtask
  task automatic send_frame(input logic [7:0] d, input logic [1:0] pt, input logic sb, input int dv,
                            input logic p, input logic s1, input logic s2, input logic scr);
    int bp;
    bp = OS * (dv + 1);
    baud_div = DW'(dv);
    parity_type = pt;
    stop_bits = sb;
    wait_n(2);
    data_tx = 0;
    t_start = cyc;
    wait_n(bp);
    if (scr) begin
      baud_div = DW'($urandom_range(0, 7));
      parity_type = 2'($urandom);
      stop_bits = 1'($urandom);
    end
    for (int i = 0; i < 8; i++) begin
      data_tx = d[i];
      wait_n(bp);
    end
    if (pt == 2'b01 || pt == 2'b10) begin
      data_tx = p;
      wait_n(bp);
    end
    data_tx = s1;
    wait_n(bp);
    if (sb) begin
      data_tx = s2;
      wait_n(bp);
    end
    data_tx = 1;
  endtask
  task automatic frame(input logic [7:0] d, input logic [1:0] pt, input logic sb, input int dv,
                       input logic p, input logic s1, input logic s2, input logic scr);
    chk_en = 0;
    send_frame(d, pt, sb, dv, p, s1, s2, scr);
    wait_n(4);
    model_push(entry(d, pt, sb, p, s1, s2));
    chk_en = 1;
    wait_n(2);
  endtask
  initial begin
    int lat, act_n;
    logic [7:0] d;
    logic [1:0] pt;
    logic sb;
    wait_n(3);
    chk("reset valid", valid, 0);
    chk("reset data_out", data_out, 0);
    chk("reset error_flag", error_flag, 0);
    chk("reset overrun", overrun_flag, 0);
    chk("reset active", active_flag, 0);
    chk("reset count", fifo_count, 0);
    reset = 0;
    wait_n(4);
    chk_en = 1;
    frame(8'hA5, 2'b10, 0, 3, 1'b0, 1, 1, 0);
    lat = rise_cyc - t_start;
    chk("push latency", (lat >= 673 && lat <= 677) ? 675 : lat, 675);
    chk("A5 data", data_out, 8'hA5);
    chk("A5 err", error_flag, 3'b000);
    drain();
    frame(8'h01, 2'b01, 0, 3, 1'b0, 1, 1, 0);
    chk("odd p0 data", data_out, 8'h01);
    chk("odd p0 err", error_flag, 3'b000);
    drain();
    frame(8'h01, 2'b01, 0, 3, 1'b1, 1, 1, 0);
    chk("odd p1 data", data_out, 8'h01);
    chk("odd p1 err", error_flag, 3'b001);
    drain();
    frame(8'h3C, 2'b00, 1, 3, 1'b0, 1, 0, 0);
    chk("stop2 data", data_out, 8'h3C);
    chk("stop2 err", error_flag, 3'b010);
    drain();
    chk_en = 0;
    baud_div = 3;
    parity_type = 2'b00;
    stop_bits = 1;
    wait_n(2);
    data_tx = 0;
    wait_n(12 * 64);
    data_tx = 1;
    wait_n(4);
    model_push(entry(8'h00, 2'b00, 1, 1'b0, 0, 0));
    chk_en = 1;
    wait_n(2);
    chk("break data", data_out, 8'h00);
    chk("break err", error_flag, 3'b110);
    drain();
    chk_en = 0;
    data_tx = 0;
    act_n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (i == 12) data_tx = 1;
      act_n += int'(active_flag);
    end
    chk("glitch active cycles", (act_n >= 30 && act_n <= 34) ? 32 : act_n, 32);
    chk("glitch valid", valid, 0);
    chk_en = 1;
    wait_n(4);
    chk_en = 0;
    for (int i = 1; i <= 5; i++) send_frame(8'(i * 8'h11), 2'b00, 0, 3, 1'b0, 1, 1, 0);
    wait_n(4);
    for (int i = 1; i <= 5; i++) model_push(entry(8'(i * 8'h11), 2'b00, 0, 1'b0, 1, 1));
    chk_en = 1;
    wait_n(1);
    chk("ovr count", fifo_count, 4);
    chk("ovr flag", overrun_flag, 1);
    for (int i = 1; i <= 4; i++) begin
      chk("ovr pop data", data_out, 8'(i * 8'h11));
      pop1();
      if (i == 1) chk("ovr cleared", overrun_flag, 0);
    end
    frame(8'h12, 2'b00, 0, 3, 1'b0, 1, 1, 0);
    frame(8'h34, 2'b00, 0, 3, 1'b0, 1, 1, 0);
    chk_en = 0;
    data_tx = 0;
    wait_n(64);
    data_tx = 1;
    wait_n(32);
    reset = 1;
    @(negedge clock);
    reset = 0;
    exp_q.delete();
    exp_ovr = 0;
    chk("mid reset valid", valid, 0);
    chk("mid reset count", fifo_count, 0);
    chk("mid reset active", active_flag, 0);
    wait_n(20);
    chk_en = 1;
    frame(8'h7E, 2'b10, 0, 3, par_bit(8'h7E, 2'b10, 0), 1, 1, 0);
    chk("after reset data", data_out, 8'h7E);
    chk("after reset err", error_flag, 3'b000);
    drain();
    repeat (25) begin
      d = 8'($urandom);
      if ($urandom_range(0, 7) == 0) d = 8'h00;
      pt = 2'($urandom_range(0, 3));
      sb = 1'($urandom_range(0, 1));
      frame(d, pt, sb, $urandom_range(0, 3), par_bit(d, pt, $urandom_range(0, 3) == 0),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 1);
      repeat ($urandom_range(0, 2)) pop1();
      wait_n($urandom_range(1, 8));
    end
    drain();
    wait_n(4);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
